// File: rtl/memory_map_pkg.sv
// Shared memory map: address-space definitions, responder FSM states and
// fetch-integrity width used by the instruction memory responder.
package memory_map_pkg;

    // Address space
    localparam logic [31:0] IMEM_BASE_ADDR  = 32'h0001_0000;
    localparam int unsigned IMEM_SIZE_BYTES = 16384;
    localparam logic [31:0] DMEM_BASE_ADDR  = 32'h0002_0000;
    localparam int unsigned DMEM_SIZE_BYTES = 16384;

    // Check bits on instruction read data (Hamming(39,32) SECDED)
    localparam int unsigned INSTR_INTG_W = 7;

    // Instruction responder FSM
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        RESPOND  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/ibex_instr_bus.sv
// Ibex-style instruction fetch bus.
// master drives req/addr; slave answers with gnt, then rvalid/rdata/err.
interface ibex_instr_bus
    import memory_map_pkg::*;
;
    logic                    req;
    logic [31:0]             addr;
    logic                    gnt;
    logic                    rvalid;
    logic [31:0]             rdata;
    logic [INSTR_INTG_W-1:0] rdata_intg;
    logic                    err;

    modport slave  (input  req, addr,
                    output gnt, rvalid, rdata, rdata_intg, err);
    modport master (output req, addr,
                    input  gnt, rvalid, rdata, rdata_intg, err);
endinterface

// File: rtl/instr_intg_gen.sv
// SECDED check-bit generator, Hamming(39,32), purely combinational.
// Data bits occupy codeword positions 1..38 that are not powers of two.
// check[5:0] : parity bit for position bit i (XOR of data at positions with bit i set)
// check[6]   : overall parity over data and check[5:0]
// Ports: data (in, 32), check (out, 7). Only built with INSTR_RDATA_INTG_EN.
`ifdef INSTR_RDATA_INTG_EN
module instr_intg_gen
    import memory_map_pkg::*;
(
    input  logic [31:0]             data,
    output logic [INSTR_INTG_W-1:0] check
);

    localparam int unsigned PAR_W = INSTR_INTG_W - 1;

    // Data-bit mask covered by parity bit 'bit_idx', resolved at elaboration.
    function automatic logic [31:0] parity_mask(input int unsigned bit_idx);
        logic [31:0] mask;
        int unsigned d;
        mask = '0;
        d    = 0;
        for (int unsigned p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (((p >> bit_idx) & 1) != 0) begin
                    mask[d[4:0]] = 1'b1;
                end
                d = d + 1;
            end
        end
        return mask;
    endfunction

    logic [PAR_W-1:0] par;

    for (genvar i = 0; i < PAR_W; i++) begin : g_par
        localparam logic [31:0] MASK = parity_mask(i);
        assign par[i] = ^(data & MASK);
    end

    assign check = {(^data) ^ (^par), par};

endmodule
`endif

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: serves Ibex instruction fetches from a
// synchronous SRAM window [BASE_ADDR, BASE_ADDR+SIZE_BYTES).
// Parameters: BASE_ADDR, SIZE_BYTES (power of two), WAIT_STATES (0..15).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   instr_bus    ibex_instr_bus.slave (req/addr in; gnt/rvalid/rdata/rdata_intg/err out)
//   mem_req      SRAM read strobe (gnt cycle of a valid access only)
//   mem_addr     SRAM word address addr[log2(SIZE_BYTES)-1:2]
//   mem_rdata    SRAM read data, valid one cycle after mem_req
// gnt, mem_req and mem_addr are combinational on req/addr in the grant cycle;
// the response phase is decoded from registered state.
// Macro INSTR_RDATA_INTG_EN: drive rdata_intg with SECDED check bits of rdata.
module instr_mem_responder
    import memory_map_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = IMEM_BASE_ADDR,
    parameter int unsigned SIZE_BYTES  = IMEM_SIZE_BYTES,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    ibex_instr_bus.slave                    instr_bus,
    output logic                            mem_req,
    output logic [$clog2(SIZE_BYTES)-3:0]   mem_addr,
    input  logic [31:0]                     mem_rdata
);

    localparam int unsigned AW       = $clog2(SIZE_BYTES);
    localparam int unsigned CNT_W    = 4;
    // One past the region, in 33 bits so a region ending at 2^32 does not wrap.
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(SIZE_BYTES);

    imem_state_e         state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;

    logic                acc_valid_c;
    logic                gnt_c;
    logic                rvalid_c;
    logic [31:0]         rdata_c;

    // Address check: inside the window and word aligned.
    always_comb begin
        acc_valid_c = ({1'b0, instr_bus.addr} >= 33'(BASE_ADDR)) &&
                      ({1'b0, instr_bus.addr} <  END_ADDR) &&
                      (instr_bus.addr[1:0] == 2'b00);
    end

    // Grant decode; forced low while reset is asserted.
    always_comb begin
        gnt_c = 1'b0;
        unique case (state_q)
            IDLE:     gnt_c = instr_bus.req && (WAIT_STATES == 0);
            WAIT_GNT: gnt_c = instr_bus.req && (cnt_q == '0);
            default:  gnt_c = 1'b0;
        endcase
        gnt_c = gnt_c && rst_n;
    end

    // FSM, wait counter and latched error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_c) begin
                        state_q <= RESPOND;
                        err_q   <= !acc_valid_c;
                    end else if (instr_bus.req) begin
                        state_q <= WAIT_GNT;
                        cnt_q   <= CNT_W'(WAIT_STATES - 1);
                    end
                end
                WAIT_GNT: begin
                    if (!instr_bus.req) begin
                        // Requester abandoned the fetch: drop it without a grant.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (gnt_c) begin
                        state_q <= RESPOND;
                        err_q   <= !acc_valid_c;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // SRAM strobe only for granted, valid accesses.
    always_comb begin
        mem_req  = gnt_c && acc_valid_c;
        mem_addr = mem_req ? instr_bus.addr[AW-1:2] : '0;
    end

    // Response phase: data and error zeroed outside rvalid.
    always_comb begin
        rvalid_c = (state_q == RESPOND);
        rdata_c  = (rvalid_c && !err_q) ? mem_rdata : 32'h0;
    end

    assign instr_bus.gnt    = gnt_c;
    assign instr_bus.rvalid = rvalid_c;
    assign instr_bus.rdata  = rdata_c;
    assign instr_bus.err    = rvalid_c && err_q;

`ifdef INSTR_RDATA_INTG_EN
    logic [INSTR_INTG_W-1:0] intg_c;

    // rdata_c is zero outside RESPOND and the code of zero is zero.
    instr_intg_gen u_intg_gen (
        .data  (rdata_c),
        .check (intg_c)
    );

    assign instr_bus.rdata_intg = rvalid_c ? intg_c : '0;
`else
    assign instr_bus.rdata_intg = '0;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed self-checking bench for instr_mem_responder.
// dut0 runs with WAIT_STATES=0, dut3 with WAIT_STATES=3; each has its own SRAM read port.
module tb_instr_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        mem_req0, mem_req3;
    logic [11:0] mem_addr0, mem_addr3;
    logic [31:0] mem_rdata0, mem_rdata3;
    logic [31:0] sram [0:4095];

    int n_checks;
    int n_errors;

    ibex_instr_bus b0 ();
    ibex_instr_bus b3 ();

    instr_mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_bus (b0),
        .mem_req   (mem_req0),
        .mem_addr  (mem_addr0),
        .mem_rdata (mem_rdata0)
    );

    instr_mem_responder #(.WAIT_STATES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_bus (b3),
        .mem_req   (mem_req3),
        .mem_addr  (mem_addr3),
        .mem_rdata (mem_rdata3)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model; junk pattern when not strobed.
    always @(posedge clk) begin
        mem_rdata0 <= mem_req0 ? sram[mem_addr0] : 32'hBAD0_BAD0;
        mem_rdata3 <= mem_req3 ? sram[mem_addr3] : 32'hBAD0_BAD0;
    end

`ifdef INSTR_RDATA_INTG_EN
    // Reference SECDED: syndrome = XOR of codeword positions of set data bits.
    function automatic logic [6:0] secded_ref(input logic [31:0] d);
        logic [5:0] syn;
        int         j;
        syn = '0;
        j   = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[j] == 1'b1) syn = syn ^ 6'(p);
                j++;
            end
        end
        return {(^d) ^ (^syn), syn};
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single WAIT_STATES=0 fetch; entered and left at posedge+1.
    task automatic fetch0(input string name, input logic [31:0] a,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [11:0] exp_maddr);
        b0.req  = 1'b1;
        b0.addr = a;
        @(negedge clk);
        check({name, ".gnt"},     32'(b0.gnt),    32'd1);
        check({name, ".mem_req"}, 32'(mem_req0),  32'(!exp_err));
        check({name, ".mem_addr"},32'(mem_addr0), exp_err ? 32'd0 : 32'(exp_maddr));
        check({name, ".rv_gnt"},  32'(b0.rvalid), 32'd0);
        next_cycle();
        b0.req = 1'b0;
        @(negedge clk);
        check({name, ".rvalid"},  32'(b0.rvalid), 32'd1);
        check({name, ".rdata"},   b0.rdata,       exp_err ? 32'd0 : exp_rd);
        check({name, ".err"},     32'(b0.err),    32'(exp_err));
        check({name, ".gnt_rsp"}, 32'(b0.gnt),    32'd0);
        check({name, ".mreq_rsp"},32'(mem_req0),  32'd0);
        next_cycle();
    endtask

    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_data [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 4096; i++) sram[i] = 32'h0;
        sram[0]     = 32'hDEAD_BEEF;
        sram[1]     = 32'h0000_0013;
        sram[2]     = 32'h00A0_0093;
        sram[3]     = 32'h0000_8067;
        sram[12'hFFF] = 32'hCAFE_F00D;
        b2b_addr = '{32'h0001_0000, 32'h0001_0004, 32'h0001_0008, 32'h0001_000C};
        b2b_data = '{32'hDEAD_BEEF, 32'h0000_0013, 32'h00A0_0093, 32'h0000_8067};

        // Reset with requests pending: everything must stay quiet.
        b0.req = 1'b1; b0.addr = 32'h0001_0004;
        b3.req = 1'b1; b3.addr = 32'h0001_0000;
        @(negedge clk);
        @(negedge clk);
        check("rst.gnt0",    32'(b0.gnt),        32'd0);
        check("rst.gnt3",    32'(b3.gnt),        32'd0);
        check("rst.rvalid0", 32'(b0.rvalid),     32'd0);
        check("rst.rdata0",  b0.rdata,           32'd0);
        check("rst.err0",    32'(b0.err),        32'd0);
        check("rst.intg0",   32'(b0.rdata_intg), 32'd0);
        check("rst.mem_req0",32'(mem_req0),      32'd0);
        b0.req = 1'b0;
        b3.req = 1'b0;
        rst_n  = 1'b1;
        next_cycle();
        next_cycle();

        // Basic zero-wait fetch, boundaries and error accesses.
        fetch0("f10004", 32'h0001_0004, 32'h0000_0013, 1'b0, 12'h001);
        fetch0("f13ffc", 32'h0001_3FFC, 32'hCAFE_F00D, 1'b0, 12'hFFF);
        fetch0("f14000", 32'h0001_4000, 32'h0,         1'b1, 12'h000);
        fetch0("f10002", 32'h0001_0002, 32'h0,         1'b1, 12'h000);
        fetch0("f0fffc", 32'h0000_FFFC, 32'h0,         1'b1, 12'h000);
        @(negedge clk);
        check("idle.rvalid0", 32'(b0.rvalid), 32'd0);
        next_cycle();

        // Back-to-back: req held, gnt on even cycles, rvalid on odd.
        b0.req  = 1'b1;
        b0.addr = b2b_addr[0];
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("b2b.gnt%0d", c),    32'(b0.gnt),    32'((c % 2) == 0));
            check($sformatf("b2b.rvalid%0d", c), 32'(b0.rvalid), 32'((c % 2) == 1));
            if ((c % 2) == 1) check($sformatf("b2b.rdata%0d", c), b0.rdata, b2b_data[c / 2]);
            next_cycle();
            if ((c % 2) == 0 && c < 6) b0.addr = b2b_addr[c / 2 + 1];
            if (c == 7) b0.req = 1'b0;
        end

        // Three wait states: gnt on cycle 3, rvalid on cycle 4.
        b3.req  = 1'b1;
        b3.addr = 32'h0001_0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("ws3.gnt%0d", c),     32'(b3.gnt),        32'(c == 3));
            check($sformatf("ws3.mem_req%0d", c), 32'(mem_req3),      32'(c == 3));
            check($sformatf("ws3.rvalid%0d", c),  32'(b3.rvalid),     32'd0);
            check($sformatf("ws3.intg%0d", c),    32'(b3.rdata_intg), 32'd0);
            next_cycle();
        end
        b3.req = 1'b0;
        @(negedge clk);
        check("ws3.rvalid", 32'(b3.rvalid), 32'd1);
        check("ws3.rdata",  b3.rdata,       32'hDEAD_BEEF);
        check("ws3.err",    32'(b3.err),    32'd0);
`ifdef INSTR_RDATA_INTG_EN
        check("ws3.intg",   32'(b3.rdata_intg), 32'(secded_ref(32'hDEAD_BEEF)));
`else
        check("ws3.intg",   32'(b3.rdata_intg), 32'd0);
`endif
        next_cycle();

        // Request withdrawn while waiting: no grant, no response.
        b3.req  = 1'b1;
        b3.addr = 32'h0001_0004;
        @(negedge clk);
        check("abort.gnt0", 32'(b3.gnt), 32'd0);
        next_cycle();
        b3.req = 1'b0;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("abort.gnt%0d", c),    32'(b3.gnt),    32'd0);
            check($sformatf("abort.rvalid%0d", c), 32'(b3.rvalid), 32'd0);
            next_cycle();
        end

        // Reset pulsed during an error response.
        b0.req  = 1'b1;
        b0.addr = 32'h0001_4000;
        @(negedge clk);
        next_cycle();
        b0.req = 1'b0;
        check("rstrsp.rvalid_pre", 32'(b0.rvalid), 32'd1);
        check("rstrsp.err_pre",    32'(b0.err),    32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstrsp.rvalid", 32'(b0.rvalid), 32'd0);
        check("rstrsp.err",    32'(b0.err),    32'd0);
        check("rstrsp.rdata",  b0.rdata,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("rstrsp.after%0d", c), 32'(b0.rvalid), 32'd0);
        end
        next_cycle();
        fetch0("post_rst", 32'h0001_0008, 32'h00A0_0093, 1'b0, 12'h002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
